// File: rtl/ccd_pkg.sv
// Shared types, constants and the pixel-to-Q8.8 lane conversion for the CCD packer.
package ccd_pkg;

  localparam int LANE_W      = 16;
  localparam int LANES_DEF   = 16;
  localparam int WORD_W      = LANE_W * LANES_DEF;
  // Pixels are MSB-aligned into this container before conversion, so the
  // conversion does not depend on the camera's pixel width.
  localparam int PIX_ALIGN_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PACK,
    FLUSH,
    DONE
  } pix_state_t;

  typedef logic [LANE_W-1:0] lane_t;

  // Upper 8 pixel bits become the Q8.8 fraction; the integer part is 0, so the
  // result always lies in [0,1).
  function automatic lane_t to_q88(input logic [PIX_ALIGN_W-1:0] pix_aligned);
    return {8'h00, pix_aligned[PIX_ALIGN_W-1 -: 8]};
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// LANES x 16-bit word assembly register: lanes fill from lane 0 upward; the
// load that fills the last lane empties the register for the next word.
module lane_shift_reg
  import ccd_pkg::*;
#(
  parameter int LANES = 16,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  lane_t                   din_i,
  output logic [LANE_W*LANES-1:0] word_o,
  output logic [IDX_W-1:0]        lane_idx_o,
  output logic                    full_o
);

  logic [IDX_W-1:0] idx_q;

  assign full_o     = (idx_q == IDX_W'(LANES - 1));
  assign lane_idx_o = idx_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      lane_t lane_q;

      // Each lane captures only when it is the current target; a completed word
      // has already been handed to the writer, so all lanes zero at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= '0;
        end else if (clear_i || (load_i && full_o)) begin
          lane_q <= '0;
        end else if (load_i && (idx_q == IDX_W'(gi))) begin
          lane_q <= din_i;
        end
      end

      assign word_o[gi*LANE_W +: LANE_W] = lane_q;
    end
  endgenerate

  // Lane index advances per load and wraps to 0 when the word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clear_i || (load_i && full_o)) begin
      idx_q <= '0;
    end else if (load_i) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ccd_pixel_packer.sv
// Packs a frame of camera pixels into 16-bit Q8.8 lanes and writes each full
// (or final partial) word to dmem port B, then pulses ccd_done.
module ccd_pixel_packer
  import ccd_pkg::*;
#(
  parameter int PIX_W   = 12,
  parameter int LANES   = 16,
  parameter int NUM_PIX = 784,
  parameter int ADDR_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    fval,
  input  logic                    pix_valid,
  input  logic [PIX_W-1:0]        pix_data,
  output logic                    dmem_wren,
  output logic [ADDR_W-1:0]       dmem_wraddr,
  output logic [LANE_W*LANES-1:0] dmem_wrdata,
  output logic                    ccd_done,
  output logic                    frame_short,
  output logic                    busy
);

  localparam int WORD_BITS = LANE_W * LANES;
  localparam int CNT_W     = $clog2(NUM_PIX + 1);
  localparam int IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NUM_WORDS = (NUM_PIX + LANES - 1) / LANES;

  generate
    if (NUM_WORDS > (2 ** ADDR_W)) begin : g_addr_check
      $error("ccd_pixel_packer: NUM_PIX/LANES words do not fit in ADDR_W address bits");
    end
    if ((PIX_W < 8) || (PIX_W > PIX_ALIGN_W)) begin : g_pix_check
      $error("ccd_pixel_packer: PIX_W must be between 8 and 32");
    end
  endgenerate

  pix_state_t             state_q, state_d;
  logic                   fval_q;
  logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic                   frame_short_q, frame_short_d;
  logic                   wren_q, wren_d;
  logic [ADDR_W-1:0]      wraddr_q, wraddr_d;
  logic [WORD_BITS-1:0]   wrdata_q, wrdata_d;
  logic                   done_q, done_d;

  logic                   fval_rise, fval_fall;
  logic                   accept, last_pix;
  logic [PIX_ALIGN_W-1:0] pix_aligned;
  lane_t                  elem;
  logic [CNT_W-1:0]       word_num;
  logic [ADDR_W-1:0]      word_idx;
  logic [WORD_BITS-1:0]   sr_word, merged_word;
  logic [IDX_W-1:0]       sr_idx;
  logic                   sr_full, sr_clear;

  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;

  // The rising-edge cycle in ARM already belongs to the frame, so its pixel counts.
  assign accept   = pix_valid && ((state_q == PACK) || ((state_q == ARM) && fval_rise));
  assign last_pix = (pix_cnt_q == CNT_W'(NUM_PIX - 1));

  assign pix_aligned = {pix_data, {(PIX_ALIGN_W - PIX_W){1'b0}}};
  assign elem        = to_q88(pix_aligned);

  // Pixels accepted so far / LANES is the index of the word being assembled.
  assign word_num = pix_cnt_q / CNT_W'(LANES);
  assign word_idx = ADDR_W'(word_num);

  // Lanes above the current index are always zero, so OR-ing in the new lane
  // yields the completed word in the same cycle it is accepted.
  assign merged_word = sr_word | (WORD_BITS'(elem) << (LANE_W * sr_idx));

  assign sr_clear = (state_q == IDLE) || (state_q == FLUSH);

  lane_shift_reg #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_lanes (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (sr_clear),
    .load_i     (accept),
    .din_i      (elem),
    .word_o     (sr_word),
    .lane_idx_o (sr_idx),
    .full_o     (sr_full)
  );

  // Next-state, counter and registered-output logic for the capture FSM.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    frame_short_d = frame_short_q;
    wren_d        = 1'b0;
    wraddr_d      = wraddr_q;
    wrdata_d      = wrdata_q;
    done_d        = 1'b0;

    if (accept) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
      if (sr_full) begin
        wren_d   = 1'b1;
        wraddr_d = word_idx;
        wrdata_d = merged_word;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          frame_short_d = 1'b0;
          pix_cnt_d     = '0;
          state_d       = ARM;
        end
      end
      ARM: begin
        if (fval_rise) begin
          state_d = PACK;
          if (accept && last_pix) begin
            state_d = sr_full ? DONE : FLUSH;
          end
        end
      end
      PACK: begin
        // A final pixel coinciding with fval falling completes the frame normally.
        if (accept && last_pix) begin
          state_d = sr_full ? DONE : FLUSH;
        end else if (fval_fall) begin
          frame_short_d = 1'b1;
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        if (sr_idx != '0) begin
          wren_d   = 1'b1;
          wraddr_d = word_idx;
          wrdata_d = sr_word;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fval_q        <= 1'b0;
      pix_cnt_q     <= '0;
      frame_short_q <= 1'b0;
      wren_q        <= 1'b0;
      wraddr_q      <= '0;
      wrdata_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fval_q        <= fval;
      pix_cnt_q     <= pix_cnt_d;
      frame_short_q <= frame_short_d;
      wren_q        <= wren_d;
      wraddr_q      <= wraddr_d;
      wrdata_q      <= wrdata_d;
      done_q        <= done_d;
    end
  end

  assign dmem_wren   = wren_q;
  assign dmem_wraddr = wraddr_q;
  assign dmem_wrdata = wrdata_q;
  assign ccd_done    = done_q;
  assign frame_short = frame_short_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Directed bench for ccd_pixel_packer: full, short, exact-word, armed mid-frame,
// gapped and reset-aborted frames, with pixel k = 5*k mod 4096.
module tb_ccd_pixel_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         fval = 1'b0;
  logic         pix_valid = 1'b0;
  logic [11:0]  pix_data = '0;
  logic         dmem_wren;
  logic [6:0]   dmem_wraddr;
  logic [255:0] dmem_wrdata;
  logic         ccd_done;
  logic         frame_short;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  logic [6:0]   wr_addr_q[$];
  logic [255:0] wr_data_q[$];

  ccd_pixel_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fval        (fval),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .dmem_wren   (dmem_wren),
    .dmem_wraddr (dmem_wraddr),
    .dmem_wrdata (dmem_wrdata),
    .ccd_done    (ccd_done),
    .frame_short (frame_short),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Record every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dmem_wren === 1'b1) begin
      wr_addr_q.push_back(dmem_wraddr);
      wr_data_q.push_back(dmem_wrdata);
      last_wr_cyc = cyc;
    end
    if (ccd_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Expected packed word i for a frame of n accepted pixels.
  function automatic logic [255:0] exp_word(input int i, input int n);
    logic [255:0] w;
    int k;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      k = 16 * i + j;
      if (k < n) w[16*j +: 16] = 16'(((5 * k) % 4096) >> 4);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    last_wr_cyc = 0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
  endtask

  // fval rises together with pixel 0; gap idle cycles follow each pixel.
  task automatic send_frame(input int n, input int gap, input bit poke_enable);
    fval = 1'b1;
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_data  = 12'((5 * k) % 4096);
      if (poke_enable && (k % 50 == 10)) enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int g = 0; g < gap; g++) begin
        pix_valid = 1'b0;
        pix_data  = 12'hABC;
        tick();
      end
    end
    pix_valid = 1'b0;
    fval = 1'b0;
    tick();
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_wr_count"}, 256'(wr_addr_q.size()), 256'(49));
    for (int i = 0; i < 49 && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, 256'(wr_addr_q[i]), 256'(i));
      chk({tag, "_data"}, wr_data_q[i], exp_word(i, 784));
    end
    chk({tag, "_done_cnt"}, 256'(done_cnt), 256'(1));
    chk({tag, "_done_gap"}, 256'(done_cyc - last_wr_cyc), 256'(1));
    chk({tag, "_frame_short"}, 256'(frame_short), 256'(0));
    chk({tag, "_busy_end"}, 256'(busy), 256'(0));
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_wren", 256'(dmem_wren), 256'(0));
    chk("rst_addr", 256'(dmem_wraddr), 256'(0));
    chk("rst_data", dmem_wrdata, 256'(0));
    chk("rst_done", 256'(ccd_done), 256'(0));
    chk("rst_short", 256'(frame_short), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    rst_n = 1'b1;
    tick();
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // Full frame, back-to-back, with 6 surplus pixels that must be ignored
    clear_log();
    start();
    chk("arm_busy", 256'(busy), 256'(1));
    send_frame(790, 0, 1'b0);
    repeat (8) tick();
    check_full("full");
    if (wr_data_q.size() == 49) begin
      chk("full_w0_lane1", 256'(wr_data_q[0][31:16]), 256'(16'h0000));
      chk("full_w0_lane15", 256'(wr_data_q[0][255:240]), 256'(16'h0004));
      chk("full_w48_lane0", 256'(wr_data_q[48][15:0]), 256'(16'h00F0));
      chk("full_w48_lane15", 256'(wr_data_q[48][255:240]), 256'(16'h00F4));
    end else begin
      chk("full_lane_words_present", 256'(wr_data_q.size()), 256'(49));
    end
    $display("step full: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    // Short frame: fval falls after 20 pixels
    clear_log();
    start();
    send_frame(20, 0, 1'b0);
    repeat (8) tick();
    chk("short_wr_count", 256'(wr_addr_q.size()), 256'(2));
    if (wr_addr_q.size() == 2) begin
      chk("short_addr0", 256'(wr_addr_q[0]), 256'(0));
      chk("short_data0", wr_data_q[0], exp_word(0, 20));
      chk("short_addr1", 256'(wr_addr_q[1]), 256'(1));
      chk("short_data1", wr_data_q[1], 256'(64'h0005_0005_0005_0005));
    end
    chk("short_flag", 256'(frame_short), 256'(1));
    chk("short_done_cnt", 256'(done_cnt), 256'(1));
    chk("short_done_gap", 256'(done_cyc - last_wr_cyc), 256'(1));
    $display("step short20: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    // Exact-word early end: fval falls after 32 pixels, no empty flush write
    clear_log();
    start();
    chk("exact_short_cleared", 256'(frame_short), 256'(0));
    send_frame(32, 0, 1'b0);
    repeat (8) tick();
    chk("exact_wr_count", 256'(wr_addr_q.size()), 256'(2));
    if (wr_addr_q.size() == 2) begin
      chk("exact_addr1", 256'(wr_addr_q[1]), 256'(1));
      chk("exact_data1", wr_data_q[1], exp_word(1, 32));
    end
    chk("exact_flag", 256'(frame_short), 256'(1));
    chk("exact_done_cnt", 256'(done_cnt), 256'(1));
    chk("exact_done_after_wr", 256'(done_cyc > last_wr_cyc), 256'(1));
    $display("step exact32: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    // Arm while a frame is already running: that frame is skipped
    clear_log();
    fval = 1'b1;
    tick();
    start();
    chk("armmid_short_cleared", 256'(frame_short), 256'(0));
    for (int k = 0; k < 5; k++) begin
      pix_valid = 1'b1;
      pix_data  = 12'hFFF;
      tick();
    end
    pix_valid = 1'b0;
    chk("armmid_no_writes", 256'(wr_addr_q.size()), 256'(0));
    chk("armmid_busy", 256'(busy), 256'(1));
    fval = 1'b0;
    tick();
    tick();
    send_frame(790, 0, 1'b0);
    repeat (8) tick();
    check_full("armmid");
    $display("step armmid: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    // Gapped pixel strobes (1 in 3) with enable pulses while busy
    clear_log();
    start();
    send_frame(790, 2, 1'b1);
    repeat (8) tick();
    check_full("gapped");
    $display("step gapped: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    // Reset asserted at pixel 400, then a clean restart
    clear_log();
    start();
    fval = 1'b1;
    for (int k = 0; k < 400; k++) begin
      pix_valid = 1'b1;
      pix_data  = 12'((5 * k) % 4096);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", 256'(dmem_wren), 256'(0));
    chk("midrst_addr", 256'(dmem_wraddr), 256'(0));
    chk("midrst_data", dmem_wrdata, 256'(0));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_done", 256'(ccd_done), 256'(0));
    chk("midrst_pre_writes", 256'(wr_addr_q.size()), 256'(24));
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    pix_valid = 1'b0;
    fval = 1'b0;
    tick();
    chk("midrst_post_writes", 256'(wr_addr_q.size()), 256'(24));
    chk("midrst_post_done", 256'(done_cnt), 256'(0));
    clear_log();
    start();
    send_frame(790, 0, 1'b0);
    repeat (8) tick();
    check_full("restart");
    $display("step reset400: writes=%0d done=%0d checks=%0d errors=%0d", wr_addr_q.size(), done_cnt, checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_pixel_packer.md
Name: ccd_pixel_packer

Overview:
- Upstream feeder for dmem port B: takes the camera's grayscale pixel stream and packs 16 pixels per 256-bit word.
- Writes the packed words over the 7-bit address / 256-bit data / write-enable interface.
- Started by the CPU's ccd_en; reports completion on ccd_done, which gates the CPU and BMEM2VGA.
- Converts 12-bit pixels to 16-bit Q8.8 network inputs in [0,1).

Parameters:
PIX_W, 12, input pixel width
LANES, 16, pixels per dmem word (fixed 16-bit lanes; word width = 16*LANES)
NUM_PIX, 784, pixels captured per frame (28x28)
ADDR_W, 7, dmem port-B address width

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  asynchronous active-low reset
enable  in  1  start request; sampled only in IDLE
fval  in  1  frame valid, already synchronised to clk
pix_valid  in  1  pixel strobe, one pixel per asserted cycle
pix_data  in  PIX_W  grayscale pixel
dmem_wren  out  1  one-cycle write strobe
dmem_wraddr  out  ADDR_W  word address
dmem_wrdata  out  16*LANES  packed word
ccd_done  out  1  one-cycle completion pulse
frame_short  out  1  set if frame ended before NUM_PIX pixels; held until next start
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; pixel counter, lane index and shift register cleared. Reset mid-frame aborts immediately, with no partial write and no done.
- Lane conversion: elem = {8'h00, pix_data[PIX_W-1 -: 8]} (upper 8 bits as the Q8.8 fraction).
- Lane order: pixel k goes to word k/LANES, bits [16*(k%LANES) +: 16], so lane 0 is the LSBs.
- IDLE: on enable=1, clear frame_short and go to ARM.
- ARM: wait for a fval rising edge (fval=1 with the previous-cycle fval=0). A frame already in progress at arm time is skipped. The rising-edge cycle moves to PACK; a pix_valid in that same cycle is accepted.
- PACK: each pix_valid stores one elem and increments the counter.
  - On the LANES-th lane, the next cycle has dmem_wren=1 with the completed word at address = word index. Address starts at 0 each frame.
  - After pixel NUM_PIX-1 is accepted: if the last word is full, it writes as above, then go to DONE. If partial, go to FLUSH.
  - Pixels after NUM_PIX in the same frame are ignored.
- Early frame end: a fval falling edge in PACK before NUM_PIX pixels sets frame_short=1 and goes to FLUSH.
- Simultaneous final pixel and fval fall: the pixel is accepted and frame_short stays 0.
- FLUSH: if the lane index is nonzero, write the partial word with unused lanes zero. If zero, write nothing. Go to DONE.
- DONE: ccd_done=1 for one cycle, exactly one cycle after the final dmem_wren (or after entry if nothing was written). Then IDLE.
- Write latency: 1 cycle from the accepting clock edge to wren. dmem_wraddr and dmem_wrdata are valid only while wren=1 and hold their values otherwise.
- enable while busy is ignored. pix_valid outside PACK is ignored. Back-to-back pix_valid every cycle is supported without stall.
- Address arithmetic: word index = floor(k/LANES), width ADDR_W. Requirement ceil(NUM_PIX/LANES) <= 2^ADDR_W, checked by an elaboration assertion. No wrap-around is permitted.

Decomposition:
- Package ccd_pkg:
  - typedef pix_state_t {IDLE, ARM, PACK, FLUSH, DONE};
  - typedef lane_t (logic [15:0]);
  - constants LANE_W=16, WORD_W=16*LANES.
  - function to_q88(pix) implementing the lane conversion.
- One sub-module, lane_shift_reg: a LANES x 16 register with lane index, load/clear and full flag.
- The FSM and counters stay in ccd_pixel_packer.

Test Plan:
- Full frame, NUM_PIX=784, pixel k = k*5 mod 4096 every cycle after fval rise:
  - 49 writes at addresses 0..48.
  - Word 0 lane 1 = 16'h0000 (pix 5 -> upper byte 0x00); lane 15 = {8'h00, (75>>4)} = 16'h0004.
  - ccd_done pulses once, 1 cycle after the addr-48 write; frame_short=0.
- Short frame: fval falls after 20 pixels:
  - Writes addr 0 (lanes 0-15), then addr 1 with lanes 0-3 data and lanes 4-15 zero.
  - frame_short=1, ccd_done once.
- Exact-word early end: fval falls after 32 pixels:
  - Writes at addr 0 and 1 only, with no empty flush write.
  - Done 1 cycle after entering DONE following the addr-1 write; frame_short=1.
- Arm mid-frame: enable while fval=1:
  - No writes until fval falls then rises.
  - Second frame captured normally from address 0.
- Gapped pix_valid (1 of 3 cycles) plus enable pulses while busy: identical data and addresses to the gap-free run, with a single ccd_done.
- rst_n low at pixel 400: all outputs 0 asynchronously, no further writes. A new enable and frame afterwards restarts at address 0.
